// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//   Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in (mod 2^WIDTH),
//   borrow_out = 1 iff a < b + borrow_in. One full_subtractor_1_bit is
//   stepped LSB-first, one bit per clock, with the borrow held in a flop.
//   Operands enter over a valid/ready handshake. The result is held under
//   a second valid/ready handshake until it is consumed.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  operand handshake (ready only in IDLE)
//   a, b, borrow_in          operands, sampled on the accept edge
//   busy                     high while RUN or DONE
//   res_valid/res_ready      result handshake (valid only in DONE)
//   diff, borrow_out         result, held until the next result overwrites it

// full_subtractor_1_bit
//   Combinational 1-bit full subtractor: a - b - bin.
// Ports:
//   a, b, bin   minuend bit, subtrahend bit, borrow in
//   d, bout     difference bit, borrow out
module full_subtractor_1_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
   logic             borrow_q;
   logic [CW-1:0]    cnt_q;
   logic             accept, run, last;
   logic             fs_d, fs_bout;

   full_subtractor_1_bit u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      start_ready = 1'b0;
      busy        = 1'b0;
      res_valid   = 1'b0;
      accept      = 1'b0;
      run         = 1'b0;
      last        = 1'b0;
      case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            run  = 1'b1;
            if (cnt_q == LAST_BIT) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
   always_comb begin
      res_next = res_sh;
      res_next[WIDTH-1] = fs_d;
      for (int unsigned i = 0; i + 1 < WIDTH; i++) res_next[i] = res_sh[i+1];
   end

   // diff/borrow_out are separate registers so that the visible result
   // changes only once per operation, on the last RUN edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         borrow_q   <= 1'b0;
         cnt_q      <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else if (accept) begin
         a_sh     <= a;
         b_sh     <= b;
         borrow_q <= borrow_in;
         cnt_q    <= '0;
      end else if (run) begin
         a_sh     <= a_sh >> 1;
         b_sh     <= b_sh >> 1;
         res_sh   <= res_next;
         borrow_q <= fs_bout;
         cnt_q    <= cnt_q + CW'(1);
         if (last) begin
            diff       <= res_next;
            borrow_out <= fs_bout;
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl
//   Directed and random checks of serial_subtractor_ctrl at WIDTH=8, plus a
//   WIDTH=1 instance for the full-subtractor truth table.
module tb_serial_subtractor_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         start_valid, start_ready, borrow_in, busy, res_valid, res_ready, borrow_out;
   logic [W-1:0] a, b, diff;

   logic s1_start_valid, s1_start_ready, s1_a, s1_b, s1_borrow_in;
   logic s1_busy, s1_res_valid, s1_res_ready, s1_diff, s1_borrow_out;

   int checks = 0;
   int errors = 0;

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .a(a), .b(b), .borrow_in(borrow_in),
      .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .diff(diff), .borrow_out(borrow_out)
   );

   serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(s1_start_valid), .start_ready(s1_start_ready),
      .a(s1_a), .b(s1_b), .borrow_in(s1_borrow_in),
      .busy(s1_busy), .res_valid(s1_res_valid), .res_ready(s1_res_ready),
      .diff(s1_diff), .borrow_out(s1_borrow_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed arithmetic, truncated to the operand width.
   function automatic logic [W:0] model(input int wd, input int unsigned x, input int unsigned y,
                                        input int unsigned bi);
      int d;
      d = int'(x) - int'(y) - int'(bi);
      model[W]     = (d < 0);
      model[W-1:0] = W'(d & ((1 << wd) - 1));
   endfunction

   task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi,
                        input int stall);
      int n;
      logic [W:0] exp;
      exp = model(W, xa, xb, xbi);
      @(negedge clk);
      n = 0;
      while (!start_ready && n < 50) begin @(negedge clk); n++; end
      check("start_ready_before_accept", start_ready, 1);
      a = xa; b = xb; borrow_in = xbi; start_valid = 1'b1; res_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
      check("busy_in_run", busy, 1);
      check("start_ready_in_run", start_ready, 0);
      n = 0;
      while (!res_valid && n < 100) begin @(posedge clk); @(negedge clk); n++; end
      check("latency", n, W);
      check("diff", diff, exp[W-1:0]);
      check("borrow_out", borrow_out, exp[W]);
      repeat (stall) begin
         @(posedge clk); @(negedge clk);
         check("hold_res_valid", res_valid, 1);
         check("hold_busy", busy, 1);
         check("hold_diff", diff, exp[W-1:0]);
         check("hold_borrow", borrow_out, exp[W]);
      end
      res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      res_ready = 1'b0;
      check("idle_start_ready", start_ready, 1);
      check("idle_res_valid", res_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_diff_held", diff, exp[W-1:0]);
   endtask

   task automatic do_op1(input logic xa, input logic xb, input logic xbi);
      int n;
      logic [W:0] exp;
      exp = model(1, xa, xb, xbi);
      @(negedge clk);
      s1_a = xa; s1_b = xb; s1_borrow_in = xbi; s1_start_valid = 1'b1; s1_res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      s1_start_valid = 1'b0;
      n = 0;
      while (!s1_res_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
      check("w1_latency", n, 1);
      check("w1_diff", s1_diff, exp[0]);
      check("w1_borrow", s1_borrow_out, exp[W]);
      @(posedge clk); @(negedge clk);
      check("w1_idle", s1_start_ready, 1);
   endtask

   initial begin : stim
      int n;
      rst_n = 1'b0;
      start_valid = 0; a = '0; b = '0; borrow_in = 0; res_ready = 0;
      s1_start_valid = 0; s1_a = 0; s1_b = 0; s1_borrow_in = 0; s1_res_ready = 0;
      #1;
      check("rst_start_ready", start_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      do_op(8'h5A, 8'h3C, 1'b0, 0);
      do_op(8'h00, 8'h01, 1'b0, 0);
      do_op(8'h10, 8'h10, 1'b1, 0);
      do_op(8'hC8, 8'h64, 1'b0, 5);

      // Operands held during RUN must be ignored; second op accepted only from IDLE
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; borrow_in = 0; start_valid = 1; res_ready = 1;
      @(posedge clk); @(negedge clk);
      a = 8'hFF; b = 8'h01;
      n = 0;
      while (!res_valid && n < 100) begin @(posedge clk); @(negedge clk); n++; end
      check("hold_sv_latency", n, W);
      check("hold_sv_diff1", diff, 8'h1E);
      check("hold_sv_ready_in_done", start_ready, 0);
      n = 0;
      while ((n == 0 || !res_valid) && n < 100) begin @(posedge clk); @(negedge clk); n++; end
      start_valid = 0;
      check("back_to_back_period", n, W + 2);
      check("hold_sv_diff2", diff, 8'hFE);
      check("hold_sv_borrow2", borrow_out, 0);
      @(posedge clk); @(negedge clk);
      res_ready = 0;
      check("hold_sv_idle", start_ready, 1);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      a = 8'h77; b = 8'h11; borrow_in = 0; start_valid = 1;
      @(posedge clk); @(negedge clk);
      start_valid = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_start_ready", start_ready, 1);
      check("async_rst_busy", busy, 0);
      check("async_rst_res_valid", res_valid, 0);
      check("async_rst_diff", diff, 0);
      check("async_rst_borrow", borrow_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("post_rst_no_valid", res_valid, 0);
      end

      // Random operations with random backpressure
      for (int i = 0; i < 40; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      // WIDTH=1 truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         do_op1(v[2], v[1], v[0]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
